// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: parity modes, shared FSM state encoding and the parity helper
// used by the configurable UART core.
package uart_cfg_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

    // Payload is zero-extended to 8 bits, so unused upper bits never change the result.
    function automatic logic parity_calc(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ^ (^data);
    endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: free-running divider emitting a one-cycle tick every DIV clocks.
module uart_os_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == W'(DIV - 1));
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/uart_cfg_core.sv
// uart_cfg_core: full-duplex UART with elaboration-time frame format, sharing one
// oversampling tick between transmitter and receiver.
module uart_cfg_core
    import uart_cfg_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE * STOP_BITS);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOP_END = CW'(OVERSAMPLE * STOP_BITS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam uart_state_e AFTER_DATA = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;

    logic tick;

    uart_os_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick_o(tick));

    uart_state_e          txs_q, txs_d, rxs_q, rxs_d;
    logic [CW-1:0]        tcnt_q, tcnt_d, rcnt_q, rcnt_d;
    logic [BW-1:0]        tbit_q, tbit_d, rbit_q, rbit_d;
    logic [DATA_BITS-1:0] tsh_q, tsh_d, rsh_q, rsh_d, rdata_q, rdata_d;
    logic                 tpar_q, tpar_d, tx_q, tx_d, tbusy_q, tbusy_d, tdone_q, tdone_d;
    logic                 s1_q, s2_q, s3_q, rpar_q, rpar_d, rferr_q, rferr_d;
    logic                 rdone_q, rdone_d, rperr_q, rperr_d, rfe_q, rfe_d, rdeliver;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txs_q   <= S_IDLE;
            tcnt_q  <= '0;
            tbit_q  <= '0;
            tsh_q   <= '0;
            tpar_q  <= 1'b0;
            tx_q    <= 1'b1;
            tbusy_q <= 1'b0;
            tdone_q <= 1'b0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
            rxs_q   <= S_IDLE;
            rcnt_q  <= '0;
            rbit_q  <= '0;
            rsh_q   <= '0;
            rpar_q  <= 1'b0;
            rferr_q <= 1'b0;
            rdata_q <= '0;
            rdone_q <= 1'b0;
            rperr_q <= 1'b0;
            rfe_q   <= 1'b0;
        end else begin
            txs_q   <= txs_d;
            tcnt_q  <= tcnt_d;
            tbit_q  <= tbit_d;
            tsh_q   <= tsh_d;
            tpar_q  <= tpar_d;
            tx_q    <= tx_d;
            tbusy_q <= tbusy_d;
            tdone_q <= tdone_d;
            s1_q    <= rx;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            rxs_q   <= rxs_d;
            rcnt_q  <= rcnt_d;
            rbit_q  <= rbit_d;
            rsh_q   <= rsh_d;
            rpar_q  <= rpar_d;
            rferr_q <= rferr_d;
            rdata_q <= rdata_d;
            rdone_q <= rdone_d;
            rperr_q <= rperr_d;
            rfe_q   <= rfe_d;
        end
    end

    always_comb begin
        txs_d  = txs_q;
        tcnt_d = tcnt_q;
        tbit_d = tbit_q;
        tsh_d  = tsh_q;
        tpar_d = tpar_q;
        if (txs_q == S_IDLE) begin
            if (tx_start) begin
                txs_d  = S_START;
                tcnt_d = '0;
                tsh_d  = tx_data;
                tpar_d = parity_calc(8'(tx_data), PARITY);
            end
        end else if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
            case (txs_q)
                S_START: if (tcnt_q == BIT_END) begin
                    tcnt_d = '0;
                    tbit_d = '0;
                    txs_d  = S_DATA;
                end
                S_DATA: if (tcnt_q == BIT_END) begin
                    tcnt_d = '0;
                    tsh_d  = tsh_q >> 1;
                    tbit_d = tbit_q + 1'b1;
                    if (tbit_q == LAST_BIT) txs_d = AFTER_DATA;
                end
                S_PARITY: if (tcnt_q == BIT_END) begin
                    tcnt_d = '0;
                    txs_d  = S_STOP;
                end
                default: if (tcnt_q == STOP_END) begin
                    tcnt_d = '0;
                    txs_d  = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are derived from next state so the line changes on the transition edge.
    always_comb begin
        tx_d    = (txs_d == S_START)  ? 1'b0     :
                  (txs_d == S_DATA)   ? tsh_d[0] :
                  (txs_d == S_PARITY) ? tpar_d   : 1'b1;
        tbusy_d = (txs_d != S_IDLE);
        tdone_d = (txs_q == S_STOP) && (txs_d == S_IDLE);
    end

    always_comb begin
        rxs_d   = rxs_q;
        rcnt_d  = rcnt_q;
        rbit_d  = rbit_q;
        rsh_d   = rsh_q;
        rpar_d  = rpar_q;
        rferr_d = rferr_q;
        if (rxs_q == S_IDLE) begin
            if (s3_q && !s2_q) begin
                rxs_d   = S_START;
                rcnt_d  = '0;
                rferr_d = 1'b0;
            end
        end else if (tick) begin
            rcnt_d = rcnt_q + 1'b1;
            case (rxs_q)
                S_START: if (rcnt_q == MID) begin
                    rcnt_d = '0;
                    rbit_d = '0;
                    rxs_d  = s2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (rcnt_q == BIT_END) begin
                    rcnt_d = '0;
                    rsh_d  = {s2_q, rsh_q[DATA_BITS-1:1]};
                    rbit_d = rbit_q + 1'b1;
                    if (rbit_q == LAST_BIT) rxs_d = AFTER_DATA;
                end
                S_PARITY: if (rcnt_q == BIT_END) begin
                    rcnt_d = '0;
                    rpar_d = s2_q;
                    rxs_d  = S_STOP;
                end
                default: begin
                    if (rcnt_q == BIT_END || rcnt_q == STOP_END) rferr_d = rferr_q | ~s2_q;
                    if (rcnt_q == STOP_END) begin
                        rcnt_d = '0;
                        rxs_d  = S_IDLE;
                    end
                end
            endcase
        end
    end

    assign rdeliver = (rxs_q == S_STOP) && (rxs_d == S_IDLE);

    always_comb begin
        rdone_d = rdeliver;
        rdata_d = rdeliver ? rsh_q : rdata_q;
        rperr_d = rdeliver ? (PARITY != PAR_NONE) && (parity_calc(8'(rsh_q), PARITY) != rpar_q) : rperr_q;
        rfe_d   = rdeliver ? rferr_d : rfe_q;
    end

    assign tx            = tx_q;
    assign tx_busy       = tbusy_q;
    assign tx_done       = tdone_q;
    assign rx_data       = rdata_q;
    assign rx_done       = rdone_q;
    assign rx_parity_err = rperr_q;
    assign rx_frame_err  = rfe_q;
endmodule

// File: tb/tb_uart_cfg_core.sv
// tb_uart_cfg_core: scoreboard bench over four frame formats (8N1, 8E1, 8O1, 7N2)
// with 160-clock bits.
module tb_uart_cfg_core;
    localparam int CF = 1_600_000;
    localparam int BR = 10_000;
    localparam int BITC = 160;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_txd = '0, a_rxd;
    logic a_start = 1'b0, a_busy, a_tdone, a_tx, a_rx, a_rdone, a_pe, a_fe, a_line = 1'b1, a_loop = 1'b0;
    logic [7:0] e_txd = '0, e_rxd;
    logic e_start = 1'b0, e_busy, e_tdone, e_tx, e_rx, e_rdone, e_pe, e_fe, e_line = 1'b1, e_loop = 1'b0;
    logic [7:0] o_txd = '0, o_rxd;
    logic o_start = 1'b0, o_busy, o_tdone, o_tx, o_rdone, o_pe, o_fe;
    logic [6:0] f_txd = '0, f_rxd;
    logic f_busy, f_tdone, f_tx, f_rdone, f_pe, f_fe, f_line = 1'b1;

    assign a_rx = a_loop ? a_tx : a_line;
    assign e_rx = e_loop ? e_tx : e_line;

    uart_cfg_core #(.CLK_FREQ(CF), .BAUD_RATE(BR)) u_a (
        .clk(clk), .rst(rst), .tx_data(a_txd), .tx_start(a_start), .tx_busy(a_busy),
        .tx_done(a_tdone), .tx(a_tx), .rx(a_rx), .rx_data(a_rxd), .rx_done(a_rdone),
        .rx_parity_err(a_pe), .rx_frame_err(a_fe));
    uart_cfg_core #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(1)) u_e (
        .clk(clk), .rst(rst), .tx_data(e_txd), .tx_start(e_start), .tx_busy(e_busy),
        .tx_done(e_tdone), .tx(e_tx), .rx(e_rx), .rx_data(e_rxd), .rx_done(e_rdone),
        .rx_parity_err(e_pe), .rx_frame_err(e_fe));
    uart_cfg_core #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(2)) u_o (
        .clk(clk), .rst(rst), .tx_data(o_txd), .tx_start(o_start), .tx_busy(o_busy),
        .tx_done(o_tdone), .tx(o_tx), .rx(o_tx), .rx_data(o_rxd), .rx_done(o_rdone),
        .rx_parity_err(o_pe), .rx_frame_err(o_fe));
    uart_cfg_core #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .STOP_BITS(2)) u_f (
        .clk(clk), .rst(rst), .tx_data(f_txd), .tx_start(1'b0), .tx_busy(f_busy),
        .tx_done(f_tdone), .tx(f_tx), .rx(f_line), .rx_data(f_rxd), .rx_done(f_rdone),
        .rx_parity_err(f_pe), .rx_frame_err(f_fe));

    exp_t qa[$], qe[$], qo[$], qf[$];
    int passed = 0, total = 0;
    int a_rxn = 0, a_txn = 0;

    always @(posedge clk) begin
        if (a_rdone) a_rxn <= a_rxn + 1;
        if (a_tdone) a_txn <= a_txn + 1;
    end

    task automatic set_line(input int id, input logic b);
        case (id)
            0:       a_line = b;
            1:       e_line = b;
            default: f_line = b;
        endcase
    endtask

    task automatic send_line(input int id, input int n, input logic [15:0] bits);
        for (int i = 0; i < n; i++) begin
            set_line(id, bits[i]);
            repeat (BITC) @(negedge clk);
        end
        set_line(id, 1'b1);
    endtask

    task automatic wait_rx(input int id, input int lim, output logic got, output exp_t obs);
        got = 1'b0;
        obs = '0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            case (id)
                0: if (a_rdone) begin got = 1'b1; obs = {a_rxd, a_pe, a_fe}; end
                1: if (e_rdone) begin got = 1'b1; obs = {e_rxd, e_pe, e_fe}; end
                2: if (o_rdone) begin got = 1'b1; obs = {o_rxd, o_pe, o_fe}; end
                default: if (f_rdone) begin got = 1'b1; obs = {1'b0, f_rxd, f_pe, f_fe}; end
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({a_tx, a_busy, a_tdone, a_rdone, a_pe, a_fe, a_rxd} !== {6'b100000, 8'h00})
            $display("FAIL reset_a observed=%b required=%b", {a_tx, a_busy, a_tdone, a_rdone, a_pe, a_fe, a_rxd}, {6'b100000, 8'h00});
        else passed++;
        total++;
        if ({f_tx, f_busy, f_tdone, f_rdone, f_pe, f_fe, f_rxd} !== {6'b100000, 7'h00})
            $display("FAIL reset_f observed=%b required=%b", {f_tx, f_busy, f_tdone, f_rdone, f_pe, f_fe, f_rxd}, {6'b100000, 7'h00});
        else passed++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if ({e_tx, e_busy, e_rdone, o_tx, o_busy, o_rdone} !== 6'b100100)
            $display("FAIL idle_after_reset observed=%b required=100100", {e_tx, e_busy, e_rdone, o_tx, o_busy, o_rdone});
        else passed++;
    endtask

    task automatic test_8n1();
        logic got;
        exp_t obs, exp;
        int cyc, n0;
        a_loop = 1'b1;
        n0 = a_rxn;
        qa.push_back('{8'hA5, 1'b0, 1'b0});
        @(negedge clk);
        a_txd = 8'hA5;
        a_start = 1'b1;
        cyc = 0;
        fork
            wait_rx(0, 2500, got, obs);
            begin
                @(negedge clk);
                a_start = 1'b0;
                cyc = 1;
                while (!a_tdone && cyc < 2500) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        exp = qa.pop_front();
        total++;
        if (got !== 1'b1) $display("FAIL 8n1_rx_done observed=%b required=1", got); else passed++;
        total++;
        if (obs !== exp) $display("FAIL 8n1_rx observed=%h/%b/%b required=%h/%b/%b", obs.d, obs.pe, obs.fe, exp.d, exp.pe, exp.fe);
        else passed++;
        total++;
        if (cyc < 1440 || cyc > 1760) $display("FAIL 8n1_tx_done_time observed=%0d required=1440..1760", cyc); else passed++;
        repeat (100) @(negedge clk);
        total++;
        if (a_rxn - n0 !== 1) $display("FAIL 8n1_rx_count observed=%0d required=1", a_rxn - n0); else passed++;
    endtask

    task automatic test_parity_bits();
        logic got_e, got_o;
        exp_t obs_e, obs_o, exp;
        e_loop = 1'b1;
        qe.push_back('{8'h03, 1'b0, 1'b0});
        qo.push_back('{8'h03, 1'b0, 1'b0});
        @(negedge clk);
        e_txd = 8'h03;
        o_txd = 8'h03;
        e_start = 1'b1;
        o_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        o_start = 1'b0;
        repeat (9 * BITC + BITC / 2 - 1) @(negedge clk);
        total++;
        if (e_tx !== 1'b0) $display("FAIL even_parity_bit observed=%b required=0", e_tx); else passed++;
        total++;
        if (o_tx !== 1'b1) $display("FAIL odd_parity_bit observed=%b required=1", o_tx); else passed++;
        fork
            wait_rx(1, 600, got_e, obs_e);
            wait_rx(2, 600, got_o, obs_o);
        join
        exp = qe.pop_front();
        total++;
        if (!got_e || obs_e !== exp) $display("FAIL 8e1_rx observed=%b:%h/%b/%b required=1:%h/%b/%b", got_e, obs_e.d, obs_e.pe, obs_e.fe, exp.d, exp.pe, exp.fe);
        else passed++;
        exp = qo.pop_front();
        total++;
        if (!got_o || obs_o !== exp) $display("FAIL 8o1_rx observed=%b:%h/%b/%b required=1:%h/%b/%b", got_o, obs_o.d, obs_o.pe, obs_o.fe, exp.d, exp.pe, exp.fe);
        else passed++;
        repeat (200) @(negedge clk);
    endtask

    task automatic test_parity_err();
        logic got;
        exp_t obs, exp;
        e_loop = 1'b0;
        qe.push_back('{8'h01, 1'b1, 1'b0});
        fork
            send_line(1, 11, {1'b1, 1'b0, 8'h01, 1'b0});
            wait_rx(1, 2500, got, obs);
        join
        exp = qe.pop_front();
        total++;
        if (!got || obs !== exp) $display("FAIL parity_err observed=%b:%h/%b/%b required=1:%h/%b/%b", got, obs.d, obs.pe, obs.fe, exp.d, exp.pe, exp.fe);
        else passed++;
    endtask

    task automatic test_frame_err();
        logic got;
        exp_t obs, exp;
        qf.push_back('{8'h55, 1'b0, 1'b1});
        fork
            send_line(3, 10, {1'b0, 1'b1, 7'h55, 1'b0});
            wait_rx(3, 2500, got, obs);
        join
        exp = qf.pop_front();
        total++;
        if (!got || obs !== exp) $display("FAIL frame_err observed=%b:%h/%b/%b required=1:%h/%b/%b", got, obs.d, obs.pe, obs.fe, exp.d, exp.pe, exp.fe);
        else passed++;
    endtask

    task automatic test_glitch();
        logic got;
        exp_t obs, exp;
        int n0;
        a_loop = 1'b0;
        n0 = a_rxn;
        @(negedge clk);
        a_line = 1'b0;
        repeat (30) @(negedge clk);
        a_line = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (a_rxn !== n0) $display("FAIL glitch_no_done observed=%0d required=%0d", a_rxn, n0); else passed++;
        qa.push_back('{8'h3C, 1'b0, 1'b0});
        fork
            send_line(0, 10, {1'b1, 8'h3C, 1'b0});
            wait_rx(0, 2500, got, obs);
        join
        exp = qa.pop_front();
        total++;
        if (!got || obs !== exp) $display("FAIL glitch_next_frame observed=%b:%h/%b/%b required=1:%h/%b/%b", got, obs.d, obs.pe, obs.fe, exp.d, exp.pe, exp.fe);
        else passed++;
    endtask

    task automatic test_busy_reset();
        logic got;
        exp_t obs, exp;
        int n0, t0;
        a_loop = 1'b1;
        n0 = a_rxn;
        t0 = a_txn;
        qa.push_back('{8'h5A, 1'b0, 1'b0});
        @(negedge clk);
        a_txd = 8'h5A;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (300) @(negedge clk);
        a_txd = 8'hFF;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_rx(0, 2500, got, obs);
        exp = qa.pop_front();
        total++;
        if (!got || obs !== exp) $display("FAIL busy_rx observed=%b:%h required=1:%h", got, obs.d, exp.d); else passed++;
        repeat (1800) @(negedge clk);
        total++;
        if ({a_txn - t0, a_rxn - n0} !== {32'd1, 32'd1}) $display("FAIL busy_ignored tx_done=%0d rx_done=%0d required 1 and 1", a_txn - t0, a_rxn - n0);
        else passed++;
        n0 = a_rxn;
        a_txd = 8'h00;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (500) @(negedge clk);
        total++;
        if ({a_tx, a_busy} !== 2'b01) $display("FAIL mid_data_line observed=%b required=01", {a_tx, a_busy}); else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({a_tx, a_busy, a_rxd} !== {2'b10, 8'h00}) $display("FAIL async_reset observed=%b required=%b", {a_tx, a_busy, a_rxd}, {2'b10, 8'h00});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (1800) @(negedge clk);
        total++;
        if ({a_rxn - n0, 31'd0, a_tx} !== {32'd0, 32'd1}) $display("FAIL partial_frame_dropped rx_done=%0d tx=%b required 0 and 1", a_rxn - n0, a_tx);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_bits();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_busy_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_cfg_core.md
# uart_cfg_core

Parametrised full-duplex UART core: one transmitter, one receiver and a shared oversampling tick generator. Frame format is set at elaboration: data bits, parity and stop bits. The receiver adds an input synchroniser, start-bit validation, and parity/framing error reporting. It replaces the fixed 8N1 UART in the design and sits between the board UART pins and the byte-level command/loopback logic.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `OVERSAMPLE`, default 16: ticks per bit; must be even and ≥ 8.
- `DATA_BITS`, default 8: payload bits per frame; legal range 5..8.
- `PARITY`, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: stop bits per frame; 1 or 2.
- `clk` in 1: the single clock; all logic is in this domain.
- `rst` in 1: asynchronous, active-high reset.
- `tx_data` in DATA_BITS: byte to send; sampled only in the cycle `tx_start` is accepted.
- `tx_start` in 1: send request; accepted only while `tx_busy` = 0.
- `tx_busy` out 1: transmitter is active.
- `tx_done` out 1: one-cycle pulse at the end of the last stop bit.
- `tx` out 1: serial output; idles high.
- `rx` in 1: asynchronous serial input.
- `rx_data` out DATA_BITS: last received payload.
- `rx_done` out 1: one-cycle pulse when a frame completes.
- `rx_parity_err` out 1: parity mismatch in the last frame.
- `rx_frame_err` out 1: a stop bit sampled low in the last frame.

## Operation
- **Tick generator**
  - `DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)`, using integer division.
  - The counter is free-running, counts 0..DIV-1 and emits a one-cycle `tick` when it reaches DIV-1.
  - One shared tick serves both TX and RX.
- **TX FSM** states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when `PARITY` = 0.
  - On acceptance, `tx_data` is latched into a shift register. The captured parity is the XOR of the payload bits, inverted for odd parity.
  - Each state holds its bit for OVERSAMPLE ticks. Data is sent LSB first.
  - STOP lasts `STOP_BITS*OVERSAMPLE` ticks.
  - `tx_start` while busy is ignored; no queueing.
- **RX input**
  - `rx` passes through a 2-FF synchroniser whose reset value is 1.
  - A falling edge on the synchronised signal in IDLE enters START.
- **RX FSM** states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - START: on tick OVERSAMPLE/2 after entry, sample the line. If it is high, this is a false start: return to IDLE with no pulse and no flag change.
  - DATA and PARITY: sample every OVERSAMPLE ticks after the start-bit midpoint. Data is shifted in LSB first.
  - STOP: sample each stop bit at its midpoint. Any low sample sets the pending frame error.
  - At the midpoint of the last stop bit, update `rx_data`, `rx_parity_err` and `rx_frame_err`, pulse `rx_done`, and go to IDLE. This allows back-to-back frames.
- Error flags are still reported with their frame; data is delivered even when a flag is set.
- Flags hold until the next `rx_done`.
- Counter widths:
  - tick-in-bit: `$clog2(OVERSAMPLE*STOP_BITS)` bits;
  - bit index: `$clog2(DATA_BITS)` bits;
  - divider: `$clog2(DIV)` bits.

## Timing
- **Reset values**: `tx`=1, `tx_busy`=0, `tx_done`=0, `rx_data`=0, `rx_done`=0, both error flags 0. Both FSMs are in IDLE and the divider is 0.
- **Reset mid-frame**: all outputs return to their reset values asynchronously. A partial frame is discarded, with no `rx_done`.
- **TX start**:
  - `tx` drops and `tx_busy` rises the clock after acceptance.
  - The start bit ends on the OVERSAMPLE-th tick after acceptance, because the tick phase is free-running.
  - All later bits are exactly `OVERSAMPLE*DIV` clocks long.
- **TX end**: `tx_done` pulses in the same cycle `tx_busy` falls. A new `tx_start` is accepted in the following cycle.
- **All outputs are registered.**
- **RX latency**: 2 synchroniser cycles plus 1 register cycle from the line to the FSM.

## Structure
- Package `uart_cfg_pkg` holds:
  - parity mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - the shared FSM state encoding;
  - a `parity_calc` function.
- Sub-module `uart_os_tick` is the parametrised tick divider, instantiated once.
- TX and RX are separate always-block pairs (registered state plus combinational next-state) inside `uart_cfg_core`.

## Test plan
Sim parameters for all scenarios: `CLK_FREQ`=1_600_000, `BAUD_RATE`=10_000, so DIV=10 and one bit is 160 clocks.
1. **8N1 loopback** (`tx`→`rx`), send 0xA5:
   - one `rx_done` with `rx_data`=0xA5 and no error flags;
   - `tx_done` 1600±160 clocks after `tx_start`.
2. **8E1 and 8O1, send 0x03**:
   - the bit after data is 0 for even parity and 1 for odd;
   - loopback gives 0x03 with no errors.
3. **Parity error** (8E1): drive frame 0x01 with parity bit 0. Expect `rx_done` with `rx_data`=0x01 and `rx_parity_err`=1.
4. **Framing error** (7N2): drive 0x55 with the second stop bit low. Expect `rx_done`, `rx_frame_err`=1, `rx_data`=0x55.
5. **Glitch**: a 30-clock low pulse on `rx`. Expect no `rx_done`, the FSM back in IDLE, and the following valid frame 0x3C received correctly.
6. **Busy and reset**:
   - a `tx_start` during a frame is ignored (only one frame on `tx`);
   - asserting `rst` mid-data forces `tx`=1 and `tx_busy`=0 immediately.
